// File: rtl/systolic_feeder.sv
// Front end of the 4x4 int8 systolic array: latches A/B on start, clears the
// array, streams both matrices diagonally skewed onto the edge buses, then drains.
module systolic_feeder #(
    parameter int DATA_W       = 8,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [16*DATA_W-1:0]  a_mat,
    input  logic [16*DATA_W-1:0]  b_mat,
    output logic                  ready,
    output logic                  busy,
    output logic                  arr_rst_n,
    output logic [DATA_W-1:0]     a0,
    output logic [DATA_W-1:0]     a1,
    output logic [DATA_W-1:0]     a2,
    output logic [DATA_W-1:0]     a3,
    output logic [DATA_W-1:0]     b0,
    output logic [DATA_W-1:0]     b1,
    output logic [DATA_W-1:0]     b2,
    output logic [DATA_W-1:0]     b3,
    output logic                  done
);
    localparam int MAT_W = 16 * DATA_W;
    localparam logic [3:0] LAST_BEAT  = 4'd6;
    localparam logic [3:0] LAST_DRAIN = 4'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, STREAM, DRAIN} state_e;

    state_e                  state_q;
    logic [3:0]              beat_q;
    logic [3:0]              beat_d;
    logic [MAT_W-1:0]        mat_a_q, mat_b_q;
    logic [3:0][DATA_W-1:0]  edge_a_q, edge_b_q;
    logic [3:0][DATA_W-1:0]  edge_a_d, edge_b_d;
    logic                    ready_q, busy_q, arr_rst_n_q, done_q;

    // Skewed beat for the cycle about to be registered: lane i lags lane 0 by i.
    always_comb begin
        beat_d = (state_q == STREAM) ? beat_q + 4'd1 : 4'd0;
        for (int i = 0; i < 4; i++) begin
            int k;
            k = int'(beat_d) - i;
            edge_a_d[i] = '0;
            edge_b_d[i] = '0;
            if (k >= 0 && k <= 3) begin
                edge_a_d[i] = mat_a_q[MAT_W-1-DATA_W*(4*i+k) -: DATA_W];
                edge_b_d[i] = mat_b_q[MAT_W-1-DATA_W*(4*k+i) -: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            mat_a_q     <= '0;
            mat_b_q     <= '0;
            edge_a_q    <= '0;
            edge_b_q    <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            arr_rst_n_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    ready_q     <= 1'b1;
                    busy_q      <= 1'b0;
                    arr_rst_n_q <= 1'b1;
                    edge_a_q    <= '0;
                    edge_b_q    <= '0;
                    if (start) begin
                        mat_a_q     <= a_mat;
                        mat_b_q     <= b_mat;
                        state_q     <= CLEAR;
                        ready_q     <= 1'b0;
                        busy_q      <= 1'b1;
                        arr_rst_n_q <= 1'b0;
                    end
                end
                CLEAR: begin
                    state_q     <= STREAM;
                    beat_q      <= '0;
                    arr_rst_n_q <= 1'b1;
                    edge_a_q    <= edge_a_d;
                    edge_b_q    <= edge_b_d;
                end
                STREAM: begin
                    // Past the last beat edge_*_d is all zero, so DRAIN starts clean.
                    edge_a_q <= edge_a_d;
                    edge_b_q <= edge_b_d;
                    if (beat_q == LAST_BEAT) begin
                        state_q <= DRAIN;
                        beat_q  <= '0;
                    end else begin
                        beat_q <= beat_q + 4'd1;
                    end
                end
                DRAIN: begin
                    edge_a_q <= '0;
                    edge_b_q <= '0;
                    if (beat_q == LAST_DRAIN) begin
                        state_q <= IDLE;
                        beat_q  <= '0;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        beat_q <= beat_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready     = ready_q;
    assign busy      = busy_q;
    assign arr_rst_n = arr_rst_n_q;
    assign done      = done_q;
    assign a0 = edge_a_q[0];
    assign a1 = edge_a_q[1];
    assign a2 = edge_a_q[2];
    assign a3 = edge_a_q[3];
    assign b0 = edge_b_q[0];
    assign b1 = edge_b_q[1];
    assign b2 = edge_b_q[2];
    assign b3 = edge_b_q[3];
endmodule
